// File: rtl/inst_queue.sv
// Dual-issue instruction queue: circular buffer with 2-wide enqueue
// and 2-wide first-word-fall-through dequeue.
module inst_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        enq_valid,
  input  logic [INST_W-1:0] enq_inst0,
  input  logic [INST_W-1:0] enq_inst1,
  input  logic [PC_W-1:0]   enq_pc0,
  input  logic [PC_W-1:0]   enq_pc1,
  output logic              enq_ready,
  input  logic [1:0]        deq_ready,
  output logic [1:0]        out_valid,
  output logic [INST_W-1:0] out_inst0,
  output logic [INST_W-1:0] out_inst1,
  output logic [PC_W-1:0]   out_pc0,
  output logic [PC_W-1:0]   out_pc1,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = INST_W + PC_W;

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq_fire0, enq_fire1;
  logic             deq_fire0, deq_fire1;
  logic [PTR_W-1:0] head1;
  logic [PTR_W-1:0] wr_addr1;

  // Two free slots are guaranteed before any enqueue is accepted,
  // so overflow cannot occur regardless of same-cycle dequeues.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));

  assign out_valid[0] = (count_q != '0);
  assign out_valid[1] = (count_q >= CNT_W'(2));

  assign head1 = head_q + PTR_W'(1);

  assign {out_inst0, out_pc0} = mem_q[head_q];
  assign {out_inst1, out_pc1} = mem_q[head1];

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    enq_fire0 = enq_valid[0] & enq_ready;
    enq_fire1 = enq_valid[1] & enq_ready;
    deq_fire0 = out_valid[0] & deq_ready[0];
    deq_fire1 = out_valid[1] & deq_ready[1] & deq_ready[0];
    wr_addr1  = enq_fire0 ? (tail_q + PTR_W'(1)) : tail_q;

    head_d  = head_q + PTR_W'(deq_fire0) + PTR_W'(deq_fire1);
    tail_d  = tail_q + PTR_W'(enq_fire0) + PTR_W'(enq_fire1);
    count_d = count_q
            + CNT_W'(enq_fire0) + CNT_W'(enq_fire1)
            - CNT_W'(deq_fire0) - CNT_W'(deq_fire1);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by out_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq_fire0) mem_q[tail_q]   <= {enq_inst0, enq_pc0};
    if (enq_fire1) mem_q[wr_addr1] <= {enq_inst1, enq_pc1};
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: scenario tasks plus a queue-based reference
// model compared against the DUT on every falling edge.
module tb_inst_queue;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [1:0]        enq_valid = 2'b00;
  logic [INST_W-1:0] enq_inst0 = '0;
  logic [INST_W-1:0] enq_inst1 = '0;
  logic [PC_W-1:0]   enq_pc0 = '0;
  logic [PC_W-1:0]   enq_pc1 = '0;
  logic              enq_ready;
  logic [1:0]        deq_ready = 2'b00;
  logic [1:0]        out_valid;
  logic [INST_W-1:0] out_inst0, out_inst1;
  logic [PC_W-1:0]   out_pc0, out_pc1;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [PC_W-1:0] pc_ctr = 32'h1C00_0000;

  logic [63:0] mq[$];

  inst_queue #(
    .INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid),
    .enq_inst0(enq_inst0), .enq_inst1(enq_inst1),
    .enq_pc0(enq_pc0), .enq_pc1(enq_pc1),
    .enq_ready(enq_ready),
    .deq_ready(deq_ready),
    .out_valid(out_valid),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference: a plain FIFO of {inst, pc}; dequeue old entries, then append.
  always @(posedge clk) begin
    int sz;
    bit rdy;
    sz  = mq.size();
    rdy = (sz <= DEPTH - 2);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (deq_ready[0] && sz >= 1) begin
        void'(mq.pop_front());
        if (deq_ready[1] && sz >= 2) void'(mq.pop_front());
      end
      if (rdy && enq_valid[0]) mq.push_back({enq_inst0, enq_pc0});
      if (rdy && enq_valid[1]) mq.push_back({enq_inst1, enq_pc1});
    end
  end

  always @(negedge clk) begin
    int sz;
    bit [1:0] ov;
    if (mon_en) begin
      sz = mq.size();
      ov = {sz >= 2, sz >= 1};
      checks++;
      if (count !== CNT_W'(sz)) begin
        errors++;
        $display("FAIL mon_count: got %0d want %0d", count, sz);
      end
      checks++;
      if (enq_ready !== (sz <= DEPTH - 2)) begin
        errors++;
        $display("FAIL mon_enq_ready: got %b want %b", enq_ready, sz <= DEPTH - 2);
      end
      checks++;
      if (out_valid !== ov) begin
        errors++;
        $display("FAIL mon_out_valid: got %b want %b", out_valid, ov);
      end
      checks++;
      if (empty !== (sz == 0) || full !== (sz == DEPTH)) begin
        errors++;
        $display("FAIL mon_flags: got e=%b f=%b want e=%b f=%b",
                 empty, full, sz == 0, sz == DEPTH);
      end
      if (sz >= 1) begin
        checks++;
        if ({out_inst0, out_pc0} !== mq[0]) begin
          errors++;
          $display("FAIL mon_lane0: got %h want %h", {out_inst0, out_pc0}, mq[0]);
        end
      end
      if (sz >= 2) begin
        checks++;
        if ({out_inst1, out_pc1} !== mq[1]) begin
          errors++;
          $display("FAIL mon_lane1: got %h want %h", {out_inst1, out_pc1}, mq[1]);
        end
      end
    end
  end

  task automatic cyc(input logic [1:0] ev, input logic [1:0] dr,
                     input logic fl, input logic r);
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    rst       = r;
    enq_inst0 = $urandom;
    enq_inst1 = $urandom;
    enq_pc0   = pc_ctr;
    enq_pc1   = pc_ctr + 32'd4;
    pc_ctr    = pc_ctr + 32'd8;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(2'b11, 2'b11, 1'b0, 1'b1);
    mon_en = 1'b1;
    checks++;
    if (out_valid !== 2'b00 || empty !== 1'b1 || full !== 1'b0 ||
        enq_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL reset: got ov=%b e=%b f=%b r=%b c=%0d want 00 1 0 1 0",
               out_valid, empty, full, enq_ready, count);
    end
  endtask

  task automatic test_basic();
    pc_ctr = 32'h1C00_0000;
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd2 || out_valid !== 2'b11) begin
      errors++;
      $display("FAIL basic_cnt: got c=%0d ov=%b want 2 11", count, out_valid);
    end
    checks++;
    if (out_pc0 !== 32'h1C00_0000 || out_pc1 !== 32'h1C00_0004) begin
      errors++;
      $display("FAIL basic_pc: got %h %h want 1c000000 1c000004", out_pc0, out_pc1);
    end
  endtask

  task automatic test_fill();
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd30 || enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_30: got c=%0d r=%b want 30 1", count, enq_ready);
    end
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd32 || full !== 1'b1 || enq_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_32: got c=%0d f=%b r=%b want 32 1 0", count, full, enq_ready);
    end
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd32) begin
      errors++;
      $display("FAIL fill_hold: got %0d want 32", count);
    end
    cyc(2'b00, 2'b01, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd31 || enq_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_deq1: got c=%0d r=%b want 31 0", count, enq_ready);
    end
    cyc(2'b11, 2'b01, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd30 || enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_reeval: got c=%0d r=%b want 30 1", count, enq_ready);
    end
  endtask

  task automatic test_single_fill();
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 31; i++)
      cyc((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd31 || enq_ready !== 1'b0 || out_valid !== 2'b11) begin
      errors++;
      $display("FAIL single_31: got c=%0d r=%b ov=%b want 31 0 11",
               count, enq_ready, out_valid);
    end
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd31 || full !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got c=%0d f=%b want 31 0", count, full);
    end
  endtask

  task automatic test_steady();
    logic [PC_W-1:0] exp_pc;
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    pc_ctr = 32'h0000_1000;
    exp_pc = 32'h0000_1000;
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (out_pc0 !== exp_pc || out_pc1 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL steady_pc[%0d]: got %h %h want %h %h",
                 i, out_pc0, out_pc1, exp_pc, exp_pc + 32'd4);
      end
      cyc(2'b11, 2'b11, 1'b0, 1'b0);
      exp_pc = exp_pc + 32'd8;
      checks++;
      if (count !== 6'd4) begin
        errors++;
        $display("FAIL steady_cnt[%0d]: got %0d want 4", i, count);
      end
    end
  endtask

  task automatic test_deq_rules();
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b11, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL deq_one: got c=%0d e=%b want 0 1", count, empty);
    end
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b10, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd3) begin
      errors++;
      $display("FAIL deq_lane1_only: got %0d want 3", count);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
      checks++;
      if (count !== 6'd10) begin
        errors++;
        $display("FAIL flush_pre[%0d]: got %0d want 10", k, count);
      end
      cyc(2'b11, 2'b11, 1'b1, k == 1);
      checks++;
      if (count !== 6'd0 || empty !== 1'b1 || out_valid !== 2'b00) begin
        errors++;
        $display("FAIL flush[%0d]: got c=%0d e=%b ov=%b want 0 1 00",
                 k, count, empty, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] dr;
    for (int i = 0; i < 600; i++) begin
      dr = 2'($urandom_range(0, 3));
      if (i < 300 && $urandom_range(0, 3) != 0) dr = 2'b00;
      cyc(2'($urandom_range(0, 3)), dr,
          $urandom_range(0, 47) == 0, $urandom_range(0, 95) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_single_fill();
    test_steady();
    test_deq_rules();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
